// File: rtl/can_id_priority_cam_if.sv
// Application-side bus of the CAN ID <-> priority table: write, lookup and reverse-read channels.
interface can_id_priority_cam_if #(
    parameter int unsigned ID_W   = 11,
    parameter int unsigned ADDR_W = 8
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ID_W-1:0]   wr_id;
    logic              wr_valid;
    logic              wr_err;
    logic              clr;
    logic              init;
    logic              lk_req;
    logic [ID_W-1:0]   lk_id;
    logic              lk_busy;
    logic              lk_done;
    logic              lk_hit;
    logic [ADDR_W-1:0] lk_prio;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [ID_W-1:0]   rd_id;
    logic              rd_hit;

    modport master (
        output wr_en, wr_addr, wr_id, wr_valid, clr, init, lk_req, lk_id, rd_req, rd_addr,
        input  wr_err, lk_busy, lk_done, lk_hit, lk_prio, rd_ack, rd_id, rd_hit
    );

    modport slave (
        input  wr_en, wr_addr, wr_id, wr_valid, clr, init, lk_req, lk_id, rd_req, rd_addr,
        output wr_err, lk_busy, lk_done, lk_hit, lk_prio, rd_ack, rd_id, rd_hit
    );
endinterface

// File: rtl/can_id_priority_cam.sv
// ID <-> priority table for CAN ID hopping: lowest-index-first sequential lookup,
// one-cycle reverse read, runtime writes, bulk clear and an identity-init sweep.
module can_id_priority_cam #(
    parameter int unsigned ID_W   = 11,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    can_id_priority_cam_if.slave bus
);
    localparam int unsigned       IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] MISS_PRIO = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_INIT
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [ID_W-1:0]    key_q, key_d;
    logic [DEPTH-1:0]   valid_q, valid_d;

    logic               wr_err_q, wr_err_d;
    logic               lk_busy_q, lk_busy_d;
    logic               lk_done_q, lk_done_d;
    logic               lk_hit_q, lk_hit_d;
    logic [ADDR_W-1:0]  lk_prio_q, lk_prio_d;
    logic               rd_ack_q;
    logic [ID_W-1:0]    rd_id_q;
    logic               rd_hit_q;

    logic [ID_W-1:0]    mem [DEPTH];
    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    logic [ID_W-1:0]    mem_wdata;

    logic               wr_in_range;
    logic               rd_in_range;
    logic [IDX_W-1:0]   wr_slot;
    logic [IDX_W-1:0]   rd_slot;
    logic [IDX_W-1:0]   idx_slot;
    logic               entry_match;

    assign wr_in_range = 32'(bus.wr_addr) < DEPTH;
    assign rd_in_range = 32'(bus.rd_addr) < DEPTH;
    assign wr_slot     = bus.wr_addr[IDX_W-1:0];
    assign rd_slot     = bus.rd_addr[IDX_W-1:0];
    assign idx_slot    = idx_q[IDX_W-1:0];
    assign entry_match = valid_q[idx_slot] && (mem[idx_slot] == key_q);

    // Next-state and next-output logic for the IDLE / SEARCH / INIT controller.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        key_d     = key_q;
        valid_d   = valid_q;
        lk_done_d = 1'b0;
        lk_hit_d  = lk_hit_q;
        lk_prio_d = lk_prio_q;
        wr_err_d  = bus.wr_en && ((state_q != ST_IDLE) || !wr_in_range);
        mem_we    = 1'b0;
        mem_waddr = wr_slot;
        mem_wdata = bus.wr_id;

        case (state_q)
            ST_IDLE: begin
                if (bus.clr) begin
                    valid_d = '0;
                end else if (bus.init) begin
                    state_d = ST_INIT;
                    idx_d   = '0;
                end else if (bus.lk_req) begin
                    state_d = ST_SEARCH;
                    idx_d   = '0;
                    key_d   = bus.lk_id;
                end
                // The write lands after a same-cycle clear and before a same-cycle search starts.
                if (bus.wr_en && wr_in_range) begin
                    mem_we           = 1'b1;
                    valid_d[wr_slot] = bus.wr_valid;
                end
            end

            ST_SEARCH: begin
                if (bus.clr) begin
                    valid_d   = '0;
                    state_d   = ST_IDLE;
                    lk_done_d = 1'b1;
                    lk_hit_d  = 1'b0;
                    lk_prio_d = MISS_PRIO;
                end else if (entry_match) begin
                    state_d   = ST_IDLE;
                    lk_done_d = 1'b1;
                    lk_hit_d  = 1'b1;
                    lk_prio_d = idx_q;
                end else if (idx_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    lk_done_d = 1'b1;
                    lk_hit_d  = 1'b0;
                    lk_prio_d = MISS_PRIO;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end

            ST_INIT: begin
                if (bus.clr) begin
                    valid_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    mem_we            = 1'b1;
                    mem_waddr         = idx_slot;
                    mem_wdata         = ID_W'(idx_q);
                    valid_d[idx_slot] = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        lk_busy_d = (state_d != ST_IDLE);
    end

    // Controller state, valid bits and lookup/write status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            key_q     <= '0;
            valid_q   <= '0;
            wr_err_q  <= 1'b0;
            lk_busy_q <= 1'b0;
            lk_done_q <= 1'b0;
            lk_hit_q  <= 1'b0;
            lk_prio_q <= MISS_PRIO;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            key_q     <= key_d;
            valid_q   <= valid_d;
            wr_err_q  <= wr_err_d;
            lk_busy_q <= lk_busy_d;
            lk_done_q <= lk_done_d;
            lk_hit_q  <= lk_hit_d;
            lk_prio_q <= lk_prio_d;
        end
    end

    // ID storage has no reset; only the valid bits define table contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Reverse read is independent of the controller and sees pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ack_q <= 1'b0;
            rd_id_q  <= '0;
            rd_hit_q <= 1'b0;
        end else begin
            rd_ack_q <= bus.rd_req;
            if (bus.rd_req) begin
                if (rd_in_range) begin
                    rd_id_q  <= mem[rd_slot];
                    rd_hit_q <= valid_q[rd_slot];
                end else begin
                    rd_id_q  <= '0;
                    rd_hit_q <= 1'b0;
                end
            end
        end
    end

    assign bus.wr_err  = wr_err_q;
    assign bus.lk_busy = lk_busy_q;
    assign bus.lk_done = lk_done_q;
    assign bus.lk_hit  = lk_hit_q;
    assign bus.lk_prio = lk_prio_q;
    assign bus.rd_ack  = rd_ack_q;
    assign bus.rd_id   = rd_id_q;
    assign bus.rd_hit  = rd_hit_q;
endmodule

// File: tb/tb_can_id_priority_cam.sv
// Bench for can_id_priority_cam: a 11-bit/16-entry instance checked every cycle against a
// table-level model, plus a 29-bit/256-entry instance for the deep lookup and mid-search reset.
module tb_can_id_priority_cam;
    logic clk = 1'b0;
    logic rst_n;
    logic rst_nb;

    always #5 clk = ~clk;

    can_id_priority_cam_if #(.ID_W(11), .ADDR_W(8)) ifa ();
    can_id_priority_cam_if #(.ID_W(29), .ADDR_W(8)) ifb ();

    can_id_priority_cam #(.ID_W(11), .DEPTH(16), .ADDR_W(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    can_id_priority_cam #(.ID_W(29), .DEPTH(256), .ADDR_W(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_nb),
        .bus   (ifb)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Table-level model of instance A: the lookup result is decided at request time from
    // the table, and only the completion time is counted down.
    int          m_mode;   // 0 idle, 1 search, 2 init
    int          m_cnt;
    logic [10:0] m_id    [16];
    bit          m_known [16];
    bit          m_valid [16];
    logic        m_res_hit;
    logic [7:0]  m_res_prio;
    logic        e_busy, e_done, e_hit, e_err, e_rack, e_rhit, e_rid_known;
    logic [7:0]  e_prio;
    logic [10:0] e_rid;
    int          wa, ra, wj;

    task automatic model_reset();
        m_mode = 0; m_cnt = 0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        e_busy = 0; e_done = 0; e_hit = 0; e_prio = 8'hFF; e_err = 0;
        e_rack = 0; e_rhit = 0; e_rid = '0; e_rid_known = 1'b1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                wa = int'(ifa.wr_addr);
                ra = int'(ifa.rd_addr);
                e_done = 1'b0;
                e_err  = ifa.wr_en && (m_mode != 0 || wa >= 16);
                e_rack = ifa.rd_req;
                if (ifa.rd_req) begin
                    if (ra < 16) begin
                        e_rhit = m_valid[ra]; e_rid = m_id[ra]; e_rid_known = m_known[ra];
                    end else begin
                        e_rhit = 1'b0; e_rid = '0; e_rid_known = 1'b1;
                    end
                end
                case (m_mode)
                    0: begin
                        if (ifa.clr) for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
                        if (ifa.wr_en && wa < 16) begin
                            m_id[wa] = ifa.wr_id; m_known[wa] = 1'b1; m_valid[wa] = ifa.wr_valid;
                        end
                        if (!ifa.clr && ifa.init) begin
                            m_mode = 2; m_cnt = 16;
                        end else if (!ifa.clr && ifa.lk_req) begin
                            m_res_hit = 1'b0; m_res_prio = 8'hFF; m_cnt = 16;
                            for (int i = 15; i >= 0; i--) begin
                                if (m_valid[i] && m_id[i] == ifa.lk_id) begin
                                    m_res_hit = 1'b1; m_res_prio = 8'(i); m_cnt = i + 1;
                                end
                            end
                            m_mode = 1;
                        end
                    end
                    1: begin
                        if (ifa.clr) begin
                            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
                            m_mode = 0; e_done = 1'b1; e_hit = 1'b0; e_prio = 8'hFF;
                        end else begin
                            m_cnt--;
                            if (m_cnt == 0) begin
                                m_mode = 0; e_done = 1'b1; e_hit = m_res_hit; e_prio = m_res_prio;
                            end
                        end
                    end
                    default: begin
                        wj = 16 - m_cnt;
                        if (ifa.clr) begin
                            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
                            m_known[wj] = 1'b0;
                            m_mode = 0;
                        end else begin
                            m_id[wj] = 11'(wj); m_known[wj] = 1'b1; m_valid[wj] = 1'b1;
                            m_cnt--;
                            if (m_cnt == 0) m_mode = 0;
                        end
                    end
                endcase
                e_busy = (m_mode != 0);
            end
        end
    end

    // Every-cycle comparison of instance A against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("a_lk_busy", 32'(ifa.lk_busy), 32'(e_busy));
            chk("a_lk_done", 32'(ifa.lk_done), 32'(e_done));
            chk("a_lk_hit",  32'(ifa.lk_hit),  32'(e_hit));
            chk("a_lk_prio", 32'(ifa.lk_prio), 32'(e_prio));
            chk("a_wr_err",  32'(ifa.wr_err),  32'(e_err));
            chk("a_rd_ack",  32'(ifa.rd_ack),  32'(e_rack));
            chk("a_rd_hit",  32'(ifa.rd_hit),  32'(e_rhit));
            if (e_rid_known) chk("a_rd_id", 32'(ifa.rd_id), 32'(e_rid));
        end
    end

    task automatic idle_a();
        ifa.wr_en = 0; ifa.wr_addr = '0; ifa.wr_id = '0; ifa.wr_valid = 0; ifa.clr = 0;
        ifa.init = 0; ifa.lk_req = 0; ifa.lk_id = '0; ifa.rd_req = 0; ifa.rd_addr = '0;
    endtask

    task automatic idle_b();
        ifb.wr_en = 0; ifb.wr_addr = '0; ifb.wr_id = '0; ifb.wr_valid = 0; ifb.clr = 0;
        ifb.init = 0; ifb.lk_req = 0; ifb.lk_id = '0; ifb.rd_req = 0; ifb.rd_addr = '0;
    endtask

    // Called at a negedge; returns at the negedge of the lk_done cycle (lat = edges after request).
    task automatic lk_a(input logic [10:0] id, input int limit, output int lat);
        ifa.lk_req = 1'b1; ifa.lk_id = id;
        @(negedge clk);
        ifa.lk_req = 1'b0; ifa.wr_en = 1'b0;
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (ifa.lk_done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wr_a(input logic [7:0] addr, input logic [10:0] id, input logic v);
        ifa.wr_en = 1'b1; ifa.wr_addr = addr; ifa.wr_id = id; ifa.wr_valid = v;
        @(negedge clk);
        ifa.wr_en = 1'b0;
    endtask

    task automatic rd_a(input logic [7:0] addr, output logic [10:0] id, output logic hit);
        ifa.rd_req = 1'b1; ifa.rd_addr = addr;
        @(negedge clk);
        ifa.rd_req = 1'b0;
        id = ifa.rd_id; hit = ifa.rd_hit;
    endtask

    int          lat, n, dones;
    logic [10:0] rid;
    logic        rhit;

    initial begin
        idle_a(); idle_b();
        rst_n = 1'b0; rst_nb = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; rst_nb = 1'b1;
        @(negedge clk);
        chk("rst_lk_prio", 32'(ifa.lk_prio), 32'hFF);
        chk("rst_lk_busy", 32'(ifa.lk_busy), 32'h0);
        chk("rst_rd_id",   32'(ifa.rd_id),   32'h0);

        // Identity init: busy for exactly 16 cycles.
        ifa.init = 1'b1;
        @(negedge clk);
        ifa.init = 1'b0;
        n = 0;
        while (ifa.lk_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("init_busy_cycles", 32'(n), 32'd16);

        lk_a(11'd5, 40, lat);
        chk("lk5_latency", 32'(lat), 32'd6);
        chk("lk5_hit", 32'(ifa.lk_hit), 32'h1);
        chk("lk5_prio", 32'(ifa.lk_prio), 32'd5);
        rd_a(8'd9, rid, rhit);
        chk("rd9_id", 32'(rid), 32'd9);
        chk("rd9_hit", 32'(rhit), 32'h1);

        // Duplicate IDs: lowest valid index wins.
        wr_a(8'd3, 11'h7FF, 1'b1);
        wr_a(8'd10, 11'h7FF, 1'b1);
        lk_a(11'h7FF, 40, lat);
        chk("dup_prio", 32'(ifa.lk_prio), 32'd3);
        chk("dup_latency", 32'(lat), 32'd4);
        wr_a(8'd3, 11'h7FF, 1'b0);
        lk_a(11'h7FF, 40, lat);
        chk("dup_inval_prio", 32'(ifa.lk_prio), 32'd10);
        chk("dup_inval_latency", 32'(lat), 32'd11);

        // Miss, requested back-to-back in the lk_done cycle.
        lk_a(11'h123, 40, lat);
        chk("miss_latency", 32'(lat), 32'd16);
        chk("miss_hit", 32'(ifa.lk_hit), 32'h0);
        chk("miss_prio", 32'(ifa.lk_prio), 32'hFF);

        // Write during SEARCH is dropped.
        ifa.lk_req = 1'b1; ifa.lk_id = 11'h7FF;
        @(negedge clk);
        ifa.lk_req = 1'b0;
        ifa.wr_en = 1'b1; ifa.wr_addr = 8'd4; ifa.wr_id = 11'h055; ifa.wr_valid = 1'b1;
        @(negedge clk);
        ifa.wr_en = 1'b0;
        chk("wr_err_search", 32'(ifa.wr_err), 32'h1);
        n = 0;
        while (!ifa.lk_done && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("search_done_seen", 32'(ifa.lk_done), 32'h1);
        rd_a(8'd4, rid, rhit);
        chk("rd4_unchanged", 32'(rid), 32'd4);

        // Out-of-range write.
        wr_a(8'd20, 11'h0AB, 1'b1);
        chk("wr_err_range", 32'(ifa.wr_err), 32'h1);

        // Clear mid-search aborts with a miss.
        ifa.lk_req = 1'b1; ifa.lk_id = 11'h7FF;
        @(negedge clk);
        ifa.lk_req = 1'b0;
        @(negedge clk);
        ifa.clr = 1'b1;
        @(negedge clk);
        ifa.clr = 1'b0;
        chk("clr_search_done", 32'(ifa.lk_done), 32'h1);
        chk("clr_search_hit", 32'(ifa.lk_hit), 32'h0);
        chk("clr_search_prio", 32'(ifa.lk_prio), 32'hFF);
        for (int i = 0; i < 16; i++) begin
            rd_a(8'(i), rid, rhit);
            chk("clr_rd_hit", 32'(rhit), 32'h0);
        end

        // clr with a write keeps only the written entry; write with lk_req is visible to the search.
        ifa.clr = 1'b1; ifa.wr_en = 1'b1; ifa.wr_addr = 8'd2; ifa.wr_id = 11'h0AA; ifa.wr_valid = 1'b1;
        @(negedge clk);
        ifa.clr = 1'b0; ifa.wr_en = 1'b0;
        lk_a(11'h0AA, 40, lat);
        chk("clrwr_prio", 32'(ifa.lk_prio), 32'd2);
        chk("clrwr_latency", 32'(lat), 32'd3);
        ifa.wr_en = 1'b1; ifa.wr_addr = 8'd7; ifa.wr_id = 11'h3C3; ifa.wr_valid = 1'b1;
        lk_a(11'h3C3, 40, lat);
        chk("wrlk_prio", 32'(ifa.lk_prio), 32'd7);
        chk("wrlk_latency", 32'(lat), 32'd8);

        // Clear aborts INIT without lk_done.
        ifa.init = 1'b1;
        @(negedge clk);
        ifa.init = 1'b0;
        repeat (4) @(negedge clk);
        ifa.clr = 1'b1;
        @(negedge clk);
        ifa.clr = 1'b0;
        chk("clr_init_busy", 32'(ifa.lk_busy), 32'h0);
        chk("clr_init_done", 32'(ifa.lk_done), 32'h0);

        // Reverse-read out of range, and read-old on a same-edge write.
        rd_a(8'd200, rid, rhit);
        chk("rd_oor_id", 32'(rid), 32'h0);
        chk("rd_oor_hit", 32'(rhit), 32'h0);
        ifa.wr_en = 1'b1; ifa.wr_addr = 8'd5; ifa.wr_id = 11'h111; ifa.wr_valid = 1'b1;
        rd_a(8'd5, rid, rhit);
        ifa.wr_en = 1'b0;
        chk("rd_old_id", 32'(rid), 32'd5);
        chk("rd_old_hit", 32'(rhit), 32'h0);
        rd_a(8'd5, rid, rhit);
        chk("rd_new_id", 32'(rid), 32'h111);
        chk("rd_new_hit", 32'(rhit), 32'h1);

        // Extended IDs, 256 entries: match at the last index.
        ifb.wr_en = 1'b1; ifb.wr_addr = 8'd255; ifb.wr_id = 29'h1FFFFFFF; ifb.wr_valid = 1'b1;
        @(negedge clk);
        ifb.wr_en = 1'b0;
        ifb.lk_req = 1'b1; ifb.lk_id = 29'h1FFFFFFF;
        @(negedge clk);
        ifb.lk_req = 1'b0;
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (ifb.lk_done) begin
                lat = i;
                break;
            end
        end
        chk("b_latency", 32'(lat), 32'd256);
        chk("b_hit", 32'(ifb.lk_hit), 32'h1);
        chk("b_prio", 32'(ifb.lk_prio), 32'd255);

        // Reset mid-search returns every output to its reset value with no lk_done.
        ifb.rd_req = 1'b1; ifb.rd_addr = 8'd255;
        @(negedge clk);
        ifb.rd_req = 1'b0;
        chk("b_rd_id", 32'(ifb.rd_id), 32'h1FFFFFFF);
        ifb.lk_req = 1'b1; ifb.lk_id = 29'h1FFFFFFF;
        @(negedge clk);
        ifb.lk_req = 1'b0;
        repeat (100) @(negedge clk);
        rst_nb = 1'b0;
        #1;
        chk("b_rst_busy", 32'(ifb.lk_busy), 32'h0);
        chk("b_rst_done", 32'(ifb.lk_done), 32'h0);
        chk("b_rst_hit", 32'(ifb.lk_hit), 32'h0);
        chk("b_rst_prio", 32'(ifb.lk_prio), 32'hFF);
        chk("b_rst_rd_id", 32'(ifb.rd_id), 32'h0);
        chk("b_rst_rd_hit", 32'(ifb.rd_hit), 32'h0);
        chk("b_rst_rd_ack", 32'(ifb.rd_ack), 32'h0);
        chk("b_rst_wr_err", 32'(ifb.wr_err), 32'h0);
        repeat (2) @(negedge clk);
        rst_nb = 1'b1;
        dones = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ifb.lk_done || ifb.lk_busy) dones++;
        end
        chk("b_no_done_after_reset", 32'(dones), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/can_id_priority_cam.md
# can_id_priority_cam

Parametrised, synthesizable ID↔priority table for the CAN ID-hopping path.
- Forward lookup: application ID → priority index, via a sequential lowest-index-first search.
- Reverse read: index → ID, registered, one cycle.
- Adds per-entry valid bits, runtime write/invalidate, bulk clear, a hardware identity-init sweep, hit/miss reporting and error flags.
- Sits between the application interface and the CAN transmit/receive ID logic.

## Interface
Parameters:
- ID_W, 11 — ID width; 11 (standard) or 29 (extended).
- DEPTH, 16 — table entries; legal range 2..256.
- ADDR_W, 8 — index/priority width; must satisfy 2^ADDR_W ≥ DEPTH.

Ports:
- clk  in  1  — single clock; all logic on the rising edge.
- rst_n  in  1  — reset, asynchronous, active-low.
- wr_en  in  1  — write strobe.
- wr_addr  in  ADDR_W  — write index.
- wr_id  in  ID_W  — ID to store.
- wr_valid  in  1  — 1: entry becomes valid; 0: entry is invalidated.
- wr_err  out  1  — one-cycle pulse; write was dropped.
- clr  in  1  — clear all valid bits.
- init  in  1  — start identity-init sweep.
- lk_req  in  1  — lookup request.
- lk_id  in  ID_W  — ID to look up.
- lk_busy  out  1  — search or init in progress.
- lk_done  out  1  — one-cycle pulse; lookup result valid.
- lk_hit  out  1  — 1 when the last lookup matched.
- lk_prio  out  ADDR_W  — matching index; all-ones on miss.
- rd_req  in  1  — reverse-read strobe.
- rd_addr  in  ADDR_W  — reverse-read index.
- rd_ack  out  1  — one-cycle pulse; reverse-read result valid.
- rd_id  out  ID_W  — stored ID.
- rd_hit  out  1  — 1 when the read entry is valid.

## Operation
- Storage: DEPTH × ID_W array plus DEPTH valid bits. Reset clears the valid bits only; array contents are not reset.
- FSM states: IDLE, SEARCH, INIT. An index counter of width ADDR_W is shared by SEARCH and INIT.
- IDLE, with priority clr > init > lk_req (lower-priority requests in the same cycle are dropped):
  - clr: all valid bits are cleared; stay in IDLE.
  - init: capture idx=0 and go to INIT.
  - lk_req: capture lk_id into the key register, set idx=0, go to SEARCH.
- Writes in IDLE:
  - Performed when wr_addr < DEPTH.
  - A write in the same cycle as lk_req commits at that edge, so the search sees the new value.
  - clr together with wr_en: clr applies to all entries, then the written entry takes wr_valid.
- SEARCH: each cycle compares entry idx (valid && id == key).
  - Match: lk_hit=1, lk_prio=idx, lk_done pulse, go to IDLE.
  - No match at idx == DEPTH-1: lk_hit=0, lk_prio=all-ones, lk_done pulse, go to IDLE.
  - Otherwise idx++.
- INIT: each cycle writes entry idx ← zero-extended idx and sets it valid. After idx == DEPTH-1, go to IDLE.
- Outside IDLE:
  - wr_en is dropped and wr_err pulses.
  - wr_en with wr_addr ≥ DEPTH is dropped in any state and wr_err pulses.
  - lk_req and init are ignored.
- clr during SEARCH: valid bits are cleared; the search aborts with a lk_done pulse, lk_hit=0, lk_prio=all-ones; go to IDLE.
- clr during INIT: valid bits are cleared and INIT aborts to IDLE. No lk_done.
- Reverse read: independent of the FSM and allowed in any state.
  - Returns the array content from before a same-edge write (read-old).
  - rd_addr ≥ DEPTH returns rd_hit=0 and rd_id=0.
- lk_hit, lk_prio, rd_id and rd_hit hold until the next lk_done / rd_ack respectively.

## Timing
- Reset values: wr_err=0, lk_busy=0, lk_done=0, lk_hit=0, lk_prio=all-ones, rd_ack=0, rd_id=0, rd_hit=0; state IDLE; idx=0.
- Reset asserted mid-operation aborts immediately with no lk_done.
- Lookup latency, lk_req sampled at edge E0:
  - Match at index k: lk_done is high for the cycle after edge E(k+1).
  - Miss: lk_done after edge E(DEPTH).
  - lk_busy is high from E0 until the edge that raises lk_done, and is low in the lk_done cycle.
  - A new lk_req is accepted in the lk_done cycle.
- Init: lk_busy is high for exactly DEPTH cycles after the init edge.
- Reverse read: rd_ack is high the cycle after rd_req is sampled; rd_id and rd_hit are valid in the same cycle.
- wr_err pulses the cycle after the offending wr_en.
- All outputs are registered.

## Test plan
- Reset → init pulse: lk_busy high 16 cycles; then lk_req lk_id=5 → lk_done 6 edges after req, lk_hit=1, lk_prio=5; rd_req rd_addr=9 → rd_id=9, rd_hit=1.
- Write entry 3 ← 0x7FF and entry 10 ← 0x7FF (valid), then lookup 0x7FF → lk_prio=3 (lowest index wins). Invalidate entry 3, repeat → lk_prio=10.
- Lookup of an absent ID 0x123 with DEPTH=16 → lk_done 16 edges after req, lk_hit=0, lk_prio=0xFF.
- wr_en during SEARCH → wr_err pulse, entry unchanged. wr_addr=20 with DEPTH=16 → wr_err pulse. clr mid-SEARCH → lk_done with lk_hit=0; all rd_hit=0 afterwards.
- ID_W=29, DEPTH=256: write entry 255 ← 0x1FFFFFFF, lookup → lk_prio=255 after 256 edges. Assert rst_n low mid-search → all outputs reach reset values with no lk_done.
